// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the majority-vote helper used to decide a bit from three samples.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int OS_RATE   = 16;
  localparam int DATA_BITS = 8;

  localparam logic [3:0] SMP_A    = 4'd7;
  localparam logic [3:0] SMP_B    = 4'd8;
  localparam logic [3:0] SMP_C    = 4'd9;
  localparam logic [3:0] SMP_LAST = 4'(OS_RATE - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick generator: one-clk pulse every OS_DIV clocks.
// Kept standalone so an oversampled transmitter can reuse it.
module uart_os_tick #(
  parameter int OS_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OS_DIV - 1);

  logic [CW-1:0] div_cnt_r;

  // Divider counter, wraps to zero on the tick cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= '0;
    end else if (div_cnt_r == CNT_MAX) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end
  end

  assign tick = (div_cnt_r == CNT_MAX);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote at samples
// 7/8/9, and a valid/ready holding register with sticky overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OS_DIV = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  logic           rx_meta_r;
  logic           rx_sync_r;
  logic           tick_s;
  uart_rx_state_t state_r,   state_s;
  logic [3:0]     smp_cnt_r, smp_cnt_s;
  logic [2:0]     bit_idx_r, bit_idx_s;
  logic [7:0]     shreg_r,   shreg_s;
  logic           smp_a_r,   smp_a_s;
  logic           smp_b_r,   smp_b_s;
  logic [7:0]     data_r,    data_s;
  logic           valid_r,   valid_s;
  logic           ferr_r,    ferr_s;
  logic           ovr_r,     ovr_s;
  logic           accept_s;
  logic           maj_s;

  uart_os_tick #(
    .OS_DIV (OS_DIV)
  ) u_os_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // Two-flop synchronizer; idle-high reset so a reset never fakes a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  assign accept_s = valid_r & rx_ready;
  assign maj_s    = majority3(smp_a_r, smp_b_r, rx_sync_r);

  // Next-state logic for the framing FSM, sample capture and holding register.
  always_comb begin
    state_s   = state_r;
    smp_cnt_s = smp_cnt_r;
    bit_idx_s = bit_idx_r;
    shreg_s   = shreg_r;
    smp_a_s   = smp_a_r;
    smp_b_s   = smp_b_r;
    data_s    = data_r;
    valid_s   = valid_r;
    ovr_s     = ovr_r;
    ferr_s    = 1'b0;

    if (accept_s) begin
      valid_s = 1'b0;
      ovr_s   = 1'b0;
    end else begin
      valid_s = valid_r;
      ovr_s   = ovr_r;
    end

    if (tick_s) begin
      smp_cnt_s = smp_cnt_r + 4'd1;
      if (smp_cnt_r == SMP_A) begin
        smp_a_s = rx_sync_r;
      end else begin
        smp_a_s = smp_a_r;
      end
      if (smp_cnt_r == SMP_B) begin
        smp_b_s = rx_sync_r;
      end else begin
        smp_b_s = smp_b_r;
      end

      case (state_r)
        IDLE: begin
          smp_cnt_s = 4'd0;
          if (!rx_sync_r) begin
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          // A start bit that is high by mid-cell was a glitch.
          if ((smp_cnt_r == SMP_C) && maj_s) begin
            state_s = IDLE;
          end else if (smp_cnt_r == SMP_LAST) begin
            state_s   = DATA;
            bit_idx_s = 3'd0;
          end else begin
            state_s = START;
          end
        end
        DATA: begin
          if (smp_cnt_r == SMP_C) begin
            shreg_s = {maj_s, shreg_r[7:1]};
          end else begin
            shreg_s = shreg_r;
          end
          if (smp_cnt_r == SMP_LAST) begin
            if (bit_idx_r == LAST_BIT) begin
              state_s = STOP;
            end else begin
              bit_idx_s = bit_idx_r + 3'd1;
            end
          end else begin
            state_s = DATA;
          end
        end
        STOP: begin
          // Decide mid-cell and leave at once so a back-to-back start is seen.
          if (smp_cnt_r == SMP_C) begin
            state_s   = IDLE;
            smp_cnt_s = 4'd0;
            if (maj_s) begin
              if (!valid_r || accept_s) begin
                data_s  = shreg_r;
                valid_s = 1'b1;
              end else begin
                ovr_s = 1'b1;
              end
            end else begin
              ferr_s = 1'b1;
            end
          end else begin
            state_s = STOP;
          end
        end
        default: begin
          state_s   = IDLE;
          smp_cnt_s = 4'd0;
        end
      endcase
    end else begin
      smp_cnt_s = smp_cnt_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      smp_cnt_r <= 4'd0;
      bit_idx_r <= 3'd0;
      shreg_r   <= 8'h00;
      smp_a_r   <= 1'b1;
      smp_b_r   <= 1'b1;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      smp_cnt_r <= smp_cnt_s;
      bit_idx_r <= bit_idx_s;
      shreg_r   <= shreg_s;
      smp_a_r   <= smp_a_s;
      smp_b_r   <= smp_b_s;
      data_r    <= data_s;
      valid_r   <= valid_s;
      ferr_r    <= ferr_s;
      ovr_r     <= ovr_s;
    end
  end

  assign rx_data   = data_r;
  assign rx_valid  = valid_r;
  assign frame_err = ferr_r;
  assign overrun   = ovr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, random frames against a
// queue-based model, and hand sequences for glitch, overrun and reset.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int OS_DIV  = 4;
  localparam int CELL_NS = 640;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.OS_DIV(OS_DIV)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int exp_ferr = 0;
  int got_ferr = 0;
  int ovr_seen = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         period;
    int         idle;
    logic [7:0] exp_byte;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  // Observe handshakes, frame errors and overrun away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) got_ferr++;
      if (overrun) ovr_seen = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int p, input int idle_cells);
    rx = 1'b0;
    #(p);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(p);
    end
    rx = stop;
    #(p);
    rx = 1'b1;
    #(p * idle_cells);
  endtask

  // Reference model with the consumer always ready: good frames deliver
  // their byte, bad stop bits produce exactly one frame error.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (stop) exp_q.push_back(d);
    else exp_ferr++;
  endtask

  task automatic check_rx(input string tag, input int exp_ovr);
    int n;
    #(CELL_NS);
    @(negedge clk);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    chk($sformatf("%s_ferr", tag), got_ferr, exp_ferr);
    chk($sformatf("%s_ovr", tag), ovr_seen, exp_ovr);
    got_q.delete();
    exp_q.delete();
    got_ferr = 0;
    exp_ferr = 0;
    ovr_seen = 0;
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 640, 0, 8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 640, 2, 8'hA3, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 640, 2, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 656, 1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 656, 1, 8'hFF, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 656, 1, 8'h5A, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 624, 1, 8'h00, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 624, 1, 8'hFF, 1'b0};
    vecs[8] = '{8'h5A, 1'b1, 624, 1, 8'h5A, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    #(CELL_NS * 2);

    // Table-driven frames: back-to-back, bad stop, +/-2.5 % baud
    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].period, vecs[v].idle);
      if (vecs[v].exp_ferr) exp_ferr++;
      else exp_q.push_back(vecs[v].exp_byte);
    end
    check_rx("table", 0);

    // 20-clk glitch must be rejected, then a normal frame
    rx = 1'b0;
    #200;
    rx = 1'b1;
    #(CELL_NS * 2);
    check_rx("glitch", 0);
    send_frame(8'h81, 1'b1, CELL_NS, 1);
    model_frame(8'h81, 1'b1);
    check_rx("after_glitch", 0);

    // Random frames with random baud offset
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      logic       s;
      int         p;
      int         idl;
      d   = 8'($urandom);
      s   = ($urandom_range(0, 4) != 0);
      p   = $urandom_range(628, 652);
      idl = s ? $urandom_range(0, 1) : 1;
      send_frame(d, s, p, idl);
      model_frame(d, s);
    end
    check_rx("random", 0);

    // Backpressure: second frame overruns, one accept clears it
    @(posedge clk);
    #1 rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, CELL_NS, 0);
    send_frame(8'h22, 1'b1, CELL_NS, 1);
    @(negedge clk);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("ovr_acc_valid", rx_valid, 1'b0);
    chk("ovr_acc_flag", overrun, 1'b0);
    exp_q.push_back(8'h11);
    check_rx("overrun", 1);
    rx_ready = 1'b1;

    // Reset in the middle of bit 4; remaining bits are all high
    fork
      send_frame(8'hF5, 1'b1, CELL_NS, 1);
      begin
        #(CELL_NS * 5 + 10);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_ferr", frame_err, 1'b0);
        chk("midrst_ovr", overrun, 1'b0);
        #29;
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check_rx("midrst_quiet", 0);
    send_frame(8'hF0, 1'b1, CELL_NS, 1);
    model_frame(8'hF0, 1'b1);
    check_rx("after_rst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART controller: recovers 8N1 frames from the `rx` line using 16× oversampling with 3-sample majority voting, and presents each byte on a valid/ready holding register. It is the receive-side counterpart of the transmit path. It derives its own oversample tick from the system clock rather than sharing the transmit-side baud clock.

## Interface
- `OS_DIV`, 27: system clocks per oversample tick (50 MHz / (115200 × 16), truncated); legal range ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronous to `clk`.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  received byte, LSB first on the wire; stable while `rx_valid` = 1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; handshake completes when `rx_valid & rx_ready` at a clock edge.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  sticky flag: a frame completed while the holding register was full. Cleared on the next accepted handshake.

## Operation
- Synchronizer: `rx` passes through 2 flops, reset value 1. All decisions use the synchronized value.
- Tick generator: counter 0..OS_DIV-1, free-running. `tick` is asserted for one clk when the count equals OS_DIV-1, then the counter wraps to 0.
- Sample counter: 4 bits, advances on each `tick`. A bit cell spans 16 ticks.
- Bit value: majority of the samples at sample counts 7, 8 and 9.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with synchronized rx = 0, go to START with the sample counter set to 0.
  - START: at sample count 9, if the majority is 1 (glitch), return to IDLE. Otherwise continue to the end of the cell (count 15), then enter DATA with the bit index at 0.
  - DATA: at count 9, shift the majority into `shreg[7]` (right shift, LSB first). At count 15, increment the bit index; after bit 7, enter STOP.
  - STOP: at count 9, evaluate the frame:
    - majority = 1: frame good. Load the holding register if empty; if full, set `overrun` and drop the byte. Return to IDLE immediately (the cell remainder is not waited out) so back-to-back start bits are caught.
    - majority = 0: pulse `frame_err`, discard the byte, and go to IDLE.
- Handshake: `rx_valid` rises on the clk after a good stop-bit decision. It falls on the clk after `rx_valid & rx_ready`.
- Simultaneous load and accept on the same edge: the new byte is loaded, `rx_valid` stays 1, and `overrun` is not set.
- The FSM never stalls on backpressure.

## Timing
- Reset values: `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, FSM = IDLE, all counters = 0.
- Start-edge detection latency: 2 clk (synchronizer) plus up to OS_DIV clk of tick quantization.
- `rx_valid` rises at 9.5625 bit cells (153 ticks) ± 1 tick after the first detected low sample, plus 1 clk.
- Tolerated baud mismatch is about ±3 % (sampling near the 9/16 point).
- Reset asserted mid-frame: the frame is abandoned and outputs return to reset values. After release, the receiver waits in IDLE for the next falling edge. A line that is already low at release is taken as a start bit only if it is still low at START validation.
- `rx` held low (break): frame_err pulses once, then the FSM re-enters START on the next tick. frame_err repeats every ~10 cells while the line stays low; this is accepted behaviour.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum (IDLE/START/DATA/STOP).
  - `OS_RATE` = 16, `DATA_BITS` = 8.
  - Sample indices `SMP_A` = 7, `SMP_B` = 8, `SMP_C` = 9.
- Sub-module `uart_os_tick`: parameter OS_DIV; ports clk, reset, tick. It is reusable by a future oversampled transmitter.
- Everything else stays flat in `uart_rx`.

## Test plan
Bench uses OS_DIV = 4, so one bit cell = 64 clk.
- Byte 0x55, then 0xA3, sent back-to-back (stop bit immediately followed by start bit), `rx_ready` tied 1 -> two `rx_valid` pulses with `rx_data` 0x55 then 0xA3; no `frame_err`, no `overrun`.
- 0x3C sent with its stop bit driven 0 -> one-clk `frame_err` pulse, `rx_valid` stays 0.
- 20-clk low glitch on idle line -> START rejects it; no output activity; the next valid frame 0x81 is received correctly.
- `rx_ready` held 0; send 0x11 then 0x22 -> `rx_data` = 0x11, `rx_valid` = 1, `overrun` = 1 after the second frame. Raise `rx_ready` for 1 clk -> `rx_valid` = 0 and `overrun` cleared.
- Reset asserted at bit 4 of a frame for 3 clk -> all outputs at reset values immediately. A subsequent 0xF0 frame is received correctly.
- Sender at +2.5 % and −2.5 % bit period, sending 0x00, 0xFF and 0x5A -> all three bytes received without error.
